// File: rtl/xreg_reader.sv
// xreg_reader: operand fetch with a per-register pending-write scoreboard and a 3-state handshake FSM.
// Optional feature: define XREG_READER_BYPASS_EN to forward same-cycle writeback data into capture.
`ifndef XLEN
`define XLEN 32
`endif

module xreg_reader #(
    parameter int PEND_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0][`XLEN-1:0] i_x,
    input  logic                   i_req_vld,
    output logic                   o_req_rdy,
    input  logic [3:0]             i_req_rs1,
    input  logic [3:0]             i_req_rs2,
    input  logic [3:0]             i_req_rd,
    input  logic                   i_req_wr,
    output logic                   o_rsp_vld,
    input  logic                   i_rsp_rdy,
    output logic [`XLEN-1:0]       o_rsp_op1,
    output logic [`XLEN-1:0]       o_rsp_op2,
    input  logic                   i_wb_vld,
    input  logic [3:0]             i_wb_idx,
    input  logic [`XLEN-1:0]       i_wb_data,
    output logic                   o_busy
);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_VALID} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PEND_W-1:0] r_pend [16];
    logic [PEND_W-1:0] w_pend_dec [16];
    logic [15:0]       w_dec;
    logic [15:0]       w_inc;
    logic [3:0]        r_rs1;
    logic [3:0]        r_rs2;
    logic [3:0]        r_rd;
    logic              r_wr;
    logic [`XLEN-1:0]  r_op1;
    logic [`XLEN-1:0]  r_op2;
    logic [3:0]        w_rs1;
    logic [3:0]        w_rs2;
    logic              w_haz1;
    logic              w_haz2;
    logic [`XLEN-1:0]  w_op1;
    logic [`XLEN-1:0]  w_op2;
    logic              w_accept;
    logic              w_capture;
    logic              w_full;
    logic              w_rsp_fire;

    // Counter view after this cycle's writeback; register 0 is never tracked.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_dec[i]      = i_wb_vld && (i_wb_idx == 4'(i)) && (i != 0) && (r_pend[i] != '0);
            w_inc[i]      = w_rsp_fire && r_wr && (r_rd != 4'd0) && (r_rd == 4'(i));
            w_pend_dec[i] = w_dec[i] ? r_pend[i] - PEND_W'(1) : r_pend[i];
        end
    end

    assign w_rs1 = (r_state == S_IDLE) ? i_req_rs1 : r_rs1;
    assign w_rs2 = (r_state == S_IDLE) ? i_req_rs2 : r_rs2;

`ifdef XREG_READER_BYPASS_EN
    assign w_haz1 = (w_rs1 != 4'd0) && (w_pend_dec[w_rs1] != '0);
    assign w_haz2 = (w_rs2 != 4'd0) && (w_pend_dec[w_rs2] != '0);
    assign w_op1  = (w_rs1 == 4'd0) ? '0 :
                    (i_wb_vld && i_wb_idx == w_rs1) ? i_wb_data : i_x[w_rs1];
    assign w_op2  = (w_rs2 == 4'd0) ? '0 :
                    (i_wb_vld && i_wb_idx == w_rs2) ? i_wb_data : i_x[w_rs2];
`else
    // Without forwarding, a tracked writeback this cycle still stalls; x is read after it lands.
    logic w_unused_wb_data;
    assign w_unused_wb_data = ^i_wb_data;
    assign w_haz1 = (w_rs1 != 4'd0) && (r_pend[w_rs1] != '0);
    assign w_haz2 = (w_rs2 != 4'd0) && (r_pend[w_rs2] != '0);
    assign w_op1  = (w_rs1 == 4'd0) ? '0 : i_x[w_rs1];
    assign w_op2  = (w_rs2 == 4'd0) ? '0 : i_x[w_rs2];
`endif

    assign o_req_rdy  = (r_state == S_IDLE);
    assign w_accept   = i_req_vld && o_req_rdy;
    // Hold the response while the destination counter has no room for one more write.
    assign w_full     = r_wr && (r_rd != 4'd0) && (w_pend_dec[r_rd] == PEND_MAX);
    assign o_rsp_vld  = (r_state == S_VALID) && !w_full;
    assign w_rsp_fire = o_rsp_vld && i_rsp_rdy;
    assign w_capture  = (w_accept || (r_state == S_WAIT)) && !w_haz1 && !w_haz2;
    assign o_rsp_op1  = r_op1;
    assign o_rsp_op2  = r_op2;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_capture ? S_VALID : S_WAIT;
            S_WAIT:  if (w_capture) w_state_nxt = S_VALID;
            S_VALID: if (w_rsp_fire) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
            r_wr    <= 1'b0;
            r_op1   <= '0;
            r_op2   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_rs1 <= i_req_rs1;
                r_rs2 <= i_req_rs2;
                r_rd  <= i_req_rd;
                r_wr  <= i_req_wr;
            end
            if (w_capture) begin
                r_op1 <= w_op1;
                r_op2 <= w_op2;
            end
        end
    end

    // NOTE: the counter array is architectural state and must be reset, unlike a datapath memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) r_pend[i] <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (w_inc[i] && !w_dec[i])
                    r_pend[i] <= r_pend[i] + PEND_W'(1);
                else if (w_dec[i] && !w_inc[i])
                    r_pend[i] <= r_pend[i] - PEND_W'(1);
            end
        end
    end

    always_comb begin
        o_busy = 1'b0;
        for (int i = 0; i < 16; i++) o_busy = o_busy | (r_pend[i] != '0);
    end

endmodule

// File: tb/tb_xreg_reader.sv
// tb_xreg_reader: directed stimulus with a response scoreboard; a negedge monitor pops and compares.
// Expected latencies follow XREG_READER_BYPASS_EN when it is defined for the build.
`ifndef XLEN
`define XLEN 32
`endif

module tb_xreg_reader;
    localparam int XW = `XLEN;

    typedef struct packed {
        logic [XW-1:0] op1;
        logic [XW-1:0] op2;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [15:0][XW-1:0] x;
    logic                req_vld;
    logic                req_rdy;
    logic [3:0]          req_rs1;
    logic [3:0]          req_rs2;
    logic [3:0]          req_rd;
    logic                req_wr;
    logic                rsp_vld;
    logic                rsp_rdy;
    logic [XW-1:0]       rsp_op1;
    logic [XW-1:0]       rsp_op2;
    logic                wb_vld;
    logic [3:0]          wb_idx;
    logic [XW-1:0]       wb_data;
    logic                busy;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    xreg_reader #(.PEND_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_x       (x),
        .i_req_vld (req_vld),
        .o_req_rdy (req_rdy),
        .i_req_rs1 (req_rs1),
        .i_req_rs2 (req_rs2),
        .i_req_rd  (req_rd),
        .i_req_wr  (req_wr),
        .o_rsp_vld (rsp_vld),
        .i_rsp_rdy (rsp_rdy),
        .o_rsp_op1 (rsp_op1),
        .o_rsp_op2 (rsp_op2),
        .i_wb_vld  (wb_vld),
        .i_wb_idx  (wb_idx),
        .i_wb_data (wb_data),
        .o_busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [XW-1:0] xv(input int v);
        return XW'(v);
    endfunction

    task automatic check(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!req_rdy && n < 50) begin
            tick();
            n++;
        end
        if (!req_rdy) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: req_rdy still %0b after %0d cycles, expected 1", name, req_rdy, n);
        end
    endtask

    task automatic issue(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                         input logic wr, input logic [XW-1:0] e1, input logic [XW-1:0] e2,
                         input bit push);
        wait_idle("issue_rdy");
        req_vld = 1'b1;
        req_rs1 = rs1;
        req_rs2 = rs2;
        req_rd  = rd;
        req_wr  = wr;
        if (push) sb_q.push_back(exp_t'{op1: e1, op2: e2});
        tick();
        req_vld = 1'b0;
    endtask

    task automatic wb_pulse(input logic [3:0] idx, input logic [XW-1:0] data);
        wb_vld  = 1'b1;
        wb_idx  = idx;
        wb_data = data;
        tick();
        wb_vld  = 1'b0;
        x[idx]  = data;
    endtask

    // Monitor: every response the DUT hands over must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rsp_vld && rsp_rdy) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got op1=%0h op2=%0h expected no response", rsp_op1, rsp_op2);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_op1", rsp_op1, mon_e.op1);
                check("sb_op2", rsp_op2, mon_e.op2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        rsp_rdy = 1'b1;
        wb_vld  = 1'b0;
        wb_idx  = '0;
        wb_data = '0;
        for (int i = 0; i < 16; i++) x[i] = xv(32'h100 + i);
        x[0] = xv(32'hDEADBEEF);
        x[3] = xv(32'h11);
        x[5] = xv(32'h22);
        req_vld = 1'b1;
        req_rs1 = 4'd3;
        req_rs2 = 4'd5;
        req_rd  = 4'd0;
        req_wr  = 1'b0;

        // Reset state, with a request already waiting.
        tick();
        tick();
        check1("rst_req_rdy", req_rdy, 1'b1);
        check1("rst_rsp_vld", rsp_vld, 1'b0);
        check("rst_op1", rsp_op1, xv(0));
        check("rst_op2", rsp_op2, xv(0));
        check1("rst_busy", busy, 1'b0);

        // First request accepted on the first edge after release, response one cycle later.
        sb_q.push_back(exp_t'{op1: xv(32'h11), op2: xv(32'h22)});
        @(posedge clk);
        #3;
        rst = 1'b0;
        tick();
        req_vld = 1'b0;
        check1("first_req_latency", rsp_vld, 1'b1);
        check1("first_req_rdy_low", req_rdy, 1'b0);
        wait_idle("first_req_done");

        // RAW hazard on x7 resolved by a writeback.
        issue(4'd1, 4'd2, 4'd7, 1'b1, xv(32'h101), xv(32'h102), 1'b1);
        wait_idle("rd7_done");
        check1("busy_pend7", busy, 1'b1);
        issue(4'd7, 4'd0, 4'd0, 1'b0, xv(32'hAB), xv(0), 1'b1);
        check1("hazard_wait", rsp_vld, 1'b0);
        check1("hazard_busy", busy, 1'b1);
        wb_vld  = 1'b1;
        wb_idx  = 4'd7;
        wb_data = xv(32'hAB);
        tick();
        wb_vld = 1'b0;
        x[7]   = xv(32'hAB);
`ifdef XREG_READER_BYPASS_EN
        check1("bypass_latency", rsp_vld, 1'b1);
`else
        check1("nobypass_stall", rsp_vld, 1'b0);
        tick();
        check1("nobypass_latency", rsp_vld, 1'b1);
`endif
        wait_idle("hazard_done");
        check1("busy_clear7", busy, 1'b0);

        // Index 0 never stalls and reads zero even with x[0] driven nonzero.
        issue(4'd1, 4'd2, 4'd9, 1'b1, xv(32'h101), xv(32'h102), 1'b1);
        wait_idle("rd9_done");
        issue(4'd0, 4'd0, 4'd0, 1'b0, xv(0), xv(0), 1'b1);
        check1("zero_src_no_stall", rsp_vld, 1'b1);
        wait_idle("zero_src_done");
        wb_pulse(4'd9, xv(32'h99));
        check1("busy_clear9", busy, 1'b0);

        // Counter saturation on rd=4: fourth issue held until a writeback frees a slot.
        for (int k = 0; k < 3; k++) begin
            issue(4'd1, 4'd2, 4'd4, 1'b1, xv(32'h101), xv(32'h102), 1'b1);
            wait_idle("rd4_fill");
        end
        check1("busy_pend4", busy, 1'b1);
        issue(4'd3, 4'd5, 4'd4, 1'b1, xv(32'h11), xv(32'h22), 1'b1);
        for (int k = 0; k < 3; k++) begin
            check1("full_stall", rsp_vld, 1'b0);
            tick();
        end
        wb_vld  = 1'b1;
        wb_idx  = 4'd4;
        wb_data = xv(32'h44);
        #1;
        check1("full_release_same_cycle", rsp_vld, 1'b1);
        tick();
        wb_vld = 1'b0;
        x[4]   = xv(32'h44);
        check1("full_release_idle", req_rdy, 1'b1);
        // Counter must still be full: inc and dec on the same edge cancel.
        issue(4'd1, 4'd2, 4'd4, 1'b1, xv(32'h101), xv(32'h102), 1'b1);
        check1("pend_still_full_a", rsp_vld, 1'b0);
        tick();
        check1("pend_still_full_b", rsp_vld, 1'b0);
        wb_pulse(4'd4, xv(32'h44));
        wait_idle("rd4_fifth_done");
        for (int k = 0; k < 3; k++) wb_pulse(4'd4, xv(32'h44));
        check1("busy_drained4", busy, 1'b0);
        wb_pulse(4'd4, xv(32'h44));
        check1("busy_saturated", busy, 1'b0);
        issue(4'd4, 4'd0, 4'd0, 1'b0, xv(32'h44), xv(0), 1'b1);
        check1("sat_no_hazard", rsp_vld, 1'b1);
        wait_idle("sat_done");

        // Backpressure: operands hold while x keeps changing.
        rsp_rdy = 1'b0;
        issue(4'd3, 4'd5, 4'd0, 1'b0, xv(32'h11), xv(32'h22), 1'b1);
        for (int k = 0; k < 5; k++) begin
            x[3] = xv(32'h300 + k);
            x[5] = xv(32'h500 + k);
            check1("hold_vld", rsp_vld, 1'b1);
            check("hold_op1", rsp_op1, xv(32'h11));
            check("hold_op2", rsp_op2, xv(32'h22));
            tick();
        end
        rsp_rdy = 1'b1;
        tick();
        check1("idle_after_hs", req_rdy, 1'b1);
        x[3] = xv(32'h11);
        x[5] = xv(32'h22);

        // Reset while WAIT drops the request and clears counters.
        issue(4'd1, 4'd2, 4'd6, 1'b1, xv(32'h101), xv(32'h102), 1'b1);
        wait_idle("rd6_done");
        issue(4'd6, 4'd0, 4'd0, 1'b0, xv(0), xv(0), 1'b0);
        check1("wait_before_rst", rsp_vld, 1'b0);
        check1("busy_before_rst", busy, 1'b1);
        rst = 1'b1;
        #1;
        check1("midrst_rsp_vld", rsp_vld, 1'b0);
        check1("midrst_busy", busy, 1'b0);
        check1("midrst_req_rdy", req_rdy, 1'b1);
        check("midrst_op1", rsp_op1, xv(0));
        @(posedge clk);
        #3;
        rst = 1'b0;
        issue(4'd6, 4'd3, 4'd0, 1'b0, xv(32'h106), xv(32'h11), 1'b1);
        check1("post_rst_latency", rsp_vld, 1'b1);
        wait_idle("post_rst_done");
        tick();

        check("sb_drained", xv(sb_q.size()), xv(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
